present80_decrypt: RTL and testbench

Iterative PRESENT-80 block decryptor. It accepts a 64-bit ciphertext and an 80-bit user key over a valid/ready handshake and runs the key schedule forward to obtain the last round key. It then executes 31 inverse rounds (inverse pLayer, inverse sLayer, round-key XOR) at one round per cycle and returns the 64-bit plaintext over a second valid/ready handshake. It is the decryption counterpart to the team's PRESENT encryption datapath, built around the inverse 4-bit S-box.

---
 rtl/present_pkg.sv | 52 +++++
 rtl/present_inv_slayer.sv | 16 +
 rtl/present80_decrypt.sv | 141 ++++++++++++++
 tb/tb_present80_decrypt.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT cipher definitions.
// Holds the forward/inverse 4-bit S-boxes, the inverse bit permutation,
// block/key widths and the decryptor FSM state encoding.
package present_pkg;

  localparam int PRESENT_ROUNDS = 31;
  localparam int BLOCK_W        = 64;
  localparam int KEY_W          = 80;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXPAND = 3'd1,
    ST_WHITEN = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } dec_state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Forward pLayer sends bit i to 16*i mod 63; since 16*4 = 64 = 1 (mod 63),
  // the inverse sends bit j to 4*j mod 63. Bit 63 is a fixed point.
  function automatic logic [63:0] inv_player(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    r[63] = d[63];
    for (int j = 0; j < 63; j++) begin
      r[(4 * j) % 63] = d[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/present_inv_slayer.sv
// present_inv_slayer: inverse PRESENT sLayer, 16 parallel inverse S-boxes.
// Latency: purely combinational, zero cycles.
// Backpressure: none (no state, no handshake).
// Ports: din (64b block in), dout (64b block out).
module present_inv_slayer
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar i = 0; i < BLOCK_W / 4; i++) begin : g_nib
    assign dout[4*i +: 4] = inv_sbox4(din[4*i +: 4]);
  end

endmodule

// File: rtl/present80_decrypt.sv
// present80_decrypt: iterative PRESENT-80 block decryptor, one round per cycle.
// Latency: 63 cycles accept-to-out_valid (32 on a key-cache hit).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_ct/in_key input
//   handshake; out_valid/out_ready/out_pt output handshake.
// Option: define PRESENT_DEC_KEYCACHE_EN to keep the last user key and its
//   expanded last round key, skipping the 31-cycle expansion on a repeat key.
module present80_decrypt
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_ct,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_pt
);

  localparam logic [4:0] RC_LAST = 5'(ROUNDS);

  dec_state_t         state_q;
  logic [BLOCK_W-1:0] s_q;
  logic [KEY_W-1:0]   k_q;
  logic [4:0]         rc_q;

  logic               accept;
  logic               expand_last;
  logic               hit;
  logic [KEY_W-1:0]   hit_k32;

  logic [KEY_W-1:0]   k_rot, k_fwd, k_x, k_xs, k_inv;
  logic [BLOCK_W-1:0] s_ip, s_is, s_round;

  assign accept      = in_valid && (state_q == ST_IDLE);
  assign expand_last = (state_q == ST_EXPAND) && (rc_q == RC_LAST);

  // Forward key update: rotl 61, S-box the top nibble, XOR counter in.
  assign k_rot = {k_q[18:0], k_q[79:19]};
  assign k_fwd = {sbox4(k_rot[79:76]), k_rot[75:20], k_rot[19:15] ^ rc_q, k_rot[14:0]};

  // Inverse key update undoes the forward steps in reverse order.
  assign k_x   = {k_q[79:20], k_q[19:15] ^ rc_q, k_q[14:0]};
  assign k_xs  = {inv_sbox4(k_x[79:76]), k_x[75:0]};
  assign k_inv = {k_xs[60:0], k_xs[79:61]};

  // Inverse round uses the freshly recovered round key in the same cycle.
  assign s_ip = inv_player(s_q);

  present_inv_slayer u_inv_slayer (
    .din  (s_ip),
    .dout (s_is)
  );

  assign s_round = s_is ^ k_inv[79:16];

`ifdef PRESENT_DEC_KEYCACHE_EN
  logic               cache_vld;
  logic [KEY_W-1:0]   cache_key;
  logic [KEY_W-1:0]   cache_k32;

  // A miss claims the cache for the new key right away but only marks it
  // valid once expansion has produced that key's K32; an abort by reset
  // therefore never leaves a half-built entry marked valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      cache_key <= '0;
      cache_k32 <= '0;
    end else begin
      if (accept && !hit) begin
        cache_vld <= 1'b0;
        cache_key <= in_key;
      end
      if (expand_last) begin
        cache_vld <= 1'b1;
        cache_k32 <= k_fwd;
      end
    end
  end

  assign hit     = cache_vld && (in_key == cache_key);
  assign hit_k32 = cache_k32;
`else
  assign hit     = 1'b0;
  assign hit_k32 = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rc_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            s_q     <= in_ct;
            k_q     <= hit ? hit_k32 : in_key;
            rc_q    <= 5'd1;
            state_q <= hit ? ST_WHITEN : ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          k_q <= k_fwd;
          // Counter saturates at the last round instead of wrapping.
          if (rc_q == RC_LAST) state_q <= ST_WHITEN;
          else                 rc_q    <= rc_q + 5'd1;
        end
        ST_WHITEN: begin
          s_q     <= s_q ^ k_q[79:16];
          rc_q    <= RC_LAST;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          k_q <= k_inv;
          s_q <= s_round;
          if (rc_q == 5'd1) state_q <= ST_DONE;
          else              rc_q    <= rc_q - 5'd1;
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state; S is only presented as the result
  // while out_valid is high.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_pt    = s_q;

endmodule

// File: tb/tb_present80_decrypt.sv
// tb_present80_decrypt: randomized self-checking bench for present80_decrypt.
// Expected plaintexts come from known vectors or from a forward-encryption
// reference model; expected latency from a small key-cache model.
module tb_present80_decrypt;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_ct;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pt;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  bit          m_cache_vld = 1'b0;
  logic [79:0] m_cache_key = '0;

  present80_decrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ct     (in_ct),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pt    (out_pt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Textbook PRESENT-80 encryption: round keys K1..K32, 31 rounds of
  // addRoundKey/sLayer/pLayer, then final whitening with K32.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s, t, p;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sbox_tab[s[4*n +: 4]];
      p = '0;
      for (int i = 0; i < 63; i++) p[(16 * i) % 63] = t[i];
      p[63] = t[63];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox_tab[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic int exp_latency(input logic [79:0] key);
    int lat;
    lat = 63;
`ifdef PRESENT_DEC_KEYCACHE_EN
    if (m_cache_vld && key == m_cache_key) lat = 32;
    m_cache_vld = 1'b1;
    m_cache_key = key;
`endif
    return lat;
  endfunction

  // Caller is always at 1 time unit after a rising edge.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk({tag, "_idle_timeout"}, 80'(in_ready), 80'd1);
  endtask

  task automatic accept_and_wait(input logic [63:0] ct, input logic [79:0] key,
                                 input string tag, output int lat);
    wait_idle(tag);
    in_ct    = ct;
    in_key   = key;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, {78'd0, out_valid, in_ready}, 80'b00);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [63:0] ct, input logic [79:0] key,
                        input logic [63:0] exp_pt, input string tag);
    int lat, elat;
    elat = exp_latency(key);
    out_ready = 1'b1;
    accept_and_wait(ct, key, tag, lat);
    chk({tag, "_lat"}, 80'(lat), 80'(elat));
    chk({tag, "_pt"}, 80'(out_pt), 80'(exp_pt));
    @(posedge clk); #1;
    chk({tag, "_b2b"}, {78'd0, out_valid, in_ready}, 80'b01);
  endtask

  initial begin
    logic [63:0] pt, ct, held;
    logic [79:0] key;
    int lat, elat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ct     = '0;
    in_key    = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_out", {15'd0, out_valid, in_ready, out_pt}, {15'd0, 1'b0, 1'b1, 64'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors.
    run_op(64'h5579C1387B228445, 80'h0, 64'h0, "kat0");
    run_op(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, "kat1");
    run_op(64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, "kat2");
    run_op(64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}, "kat3");

    // Output backpressure with a competing input offered while busy.
    pt  = {$urandom(), $urandom()};
    key = {16'($urandom()), $urandom(), $urandom()};
    ct  = ref_encrypt(pt, key);
    elat = exp_latency(key);
    out_ready = 1'b0;
    accept_and_wait(ct, key, "bp", lat);
    chk("bp_lat", 80'(lat), 80'(elat));
    chk("bp_pt", 80'(out_pt), 80'(pt));
    held     = out_pt;
    in_ct    = ~ct;
    in_key   = ~key;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {14'd0, out_valid, in_ready, out_pt}, {14'd0, 1'b1, 1'b0, held});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_release", {78'd0, out_valid, in_ready}, 80'b01);

    // Asynchronous reset at cycle 40 of an all-zero-key operation (after the
    // expansion finished, so any cached entry must be discarded by reset).
    in_ct    = 64'h5579C1387B228445;
    in_key   = 80'h0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {15'd0, out_valid, in_ready, out_pt}, {15'd0, 1'b0, 1'b1, 64'd0});
    m_cache_vld = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full latency after reset, then a repeat key (cache hit when enabled),
    // then a changed key.
    run_op(64'h5579C1387B228445, 80'h0, 64'h0, "post_rst");
    run_op(64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, "same_key");
    run_op(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, "new_key");

    // Random plaintexts; every other operation reuses the previous key.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) key = {16'($urandom()), $urandom(), $urandom()};
      pt = {$urandom(), $urandom()};
      ct = ref_encrypt(pt, key);
      run_op(ct, key, pt, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
